armleocpu_mem_arbiter: RTL and testbench
========================================

Name: armleocpu_mem_arbiter

Overview:
Two-requester arbiter sharing the single Avalon-style memory port (34-bit address, burstcount, waitrequest, response) between the instruction-fetch cache lane (m0) and the data cache lane (m1). It grants one requester for a whole burst, forwards that requester's command, write beats and read beats to and from the shared slave port, and locks the other requester out until the burst completes. Round-robin fairness applies by default.

Parameters:
ADDR_W, 34, address width, matching cache m_address.
BURST_W, 5, burstcount width. Legal burst lengths are 1..16; a value of 0 is treated as 1.

Ports:
clk  in  1  clock; all state updates on its rising edge
rst  in  1  asynchronous reset, active-high
mN_address  in  ADDR_W  requester N address, N=0,1
mN_burstcount  in  BURST_W  requester N burst length
mN_read / mN_write  in  1  requester N command strobes; never both set
mN_writedata  in  32  requester N write beat
mN_byteenable  in  4  requester N byte lanes
mN_waitrequest  out  1  stall to requester N
mN_readdata  out  32  slave readdata, broadcast to both requesters
mN_response  out  2  slave response, broadcast to both requesters
mN_readdatavalid  out  1  read beat valid for requester N only
s_address, s_burstcount, s_read, s_write, s_writedata, s_byteenable  out  widths as above  shared slave command
s_waitrequest, s_readdata, s_readdatavalid, s_response  in  1/32/1/2  shared slave returns

Behaviour:
- FSM states: IDLE, RBURST, WBURST. Register beats_left (BURST_W bits), owner (1 bit) and last_grant (1 bit).
- Reset (async, rst=1):
  - state=IDLE, beats_left=0, owner=0, last_grant=1.
  - Outputs: s_read=0, s_write=0, both mN_waitrequest=1, both mN_readdatavalid=0.
  - A burst in flight is abandoned. Beats the slave returns after reset are dropped.
- IDLE:
  - req_N = mN_read | mN_write.
  - Grant selection is combinational in the same cycle. With one request, grant it. With both, grant !last_grant.
  - The granted requester's command and data drive s_*. Its mN_waitrequest = s_waitrequest; the other requester sees waitrequest=1.
  - No request: s_read=s_write=0 and the other s_* fields are don't-care (drive 0).
- Command acceptance: (s_read|s_write) & !s_waitrequest.
  - Read accepted: owner=grant, beats_left=max(burstcount,1), go to RBURST.
  - Write accepted with length 1: the burst completes in the same cycle; last_grant=grant, stay in IDLE.
  - Write accepted with length >1: owner=grant, beats_left=length-1, go to WBURST.
- RBURST:
  - s_read=0 and s_write=0. Both mN_waitrequest=1; no new commands are accepted.
  - A beat with s_readdatavalid=1 drives m[owner]_readdatavalid=1 and decrements beats_left.
  - Every beat counts, including beats with s_response!=0 (error). The error is passed through on mN_response.
  - On the beat where beats_left==1: go to IDLE, last_grant=owner. The next arbitration is possible in the following cycle.
- WBURST:
  - Only the owner drives s_write/s_writedata/s_byteenable/s_address. m[owner]_waitrequest = s_waitrequest; the other requester's waitrequest=1.
  - s_burstcount is held at the latched value.
  - Each accepted beat decrements beats_left. When the accepted beat has beats_left==1: go to IDLE, last_grant=owner.
  - The owner dropping mN_write mid-burst stalls the burst. It is not an abort.
- s_readdatavalid in IDLE or WBURST is ignored: both mN_readdatavalid=0.
- The datapath is not pipelined: at most one burst is outstanding, and there is no registered latency on forwarded signals. Arbitration adds 0 cycles when the bus is idle.
- A request arriving on the cycle a burst ends waits one cycle, until IDLE is re-entered.

Optional Feature:
Macro ARMLEOCPU_ARB_FIXED_PRIORITY_EN.
- Defined: m0 (fetch) always wins a simultaneous request. last_grant is still maintained but is unused for selection.
- Undefined (default): round-robin as above. With both requesters asserting continuously, grants alternate m0, m1, m0, ...

Test Plan:
- m0 read, burst 4, slave returns 4 beats 0xA0..0xA3 with response 00 -> m0_readdatavalid high on exactly 4 cycles carrying 0xA0..0xA3; m1_readdatavalid stays 0; FSM back in IDLE after the 4th beat.
- m0 and m1 both read, burst 1, starting from reset -> m0 granted first, then m1. With both held asserting, a third grant goes to m0. With ARMLEOCPU_ARB_FIXED_PRIORITY_EN defined, every grant goes to m0.
- m1 write, burst 3, s_waitrequest=1 for 2 cycles on beat 2 -> exactly 3 beats accepted, in order. m0 read asserted during the burst sees waitrequest=1 until the burst ends, then is granted.
- m0 read, burst 2, first beat response 11 -> both beats delivered to m0 with m0_response=11 then 00; the burst completes normally.
- rst asserted after beat 1 of a burst-4 read -> outputs go to reset values immediately; the 3 late s_readdatavalid beats are not forwarded. A fresh m1 read after reset is granted in IDLE.
- burstcount=0 read -> treated as 1 beat: one readdatavalid, then IDLE.

Source files
------------

// File: rtl/armleocpu_mem_arbiter.sv
// armleocpu_mem_arbiter: two-requester arbiter for the shared Avalon-style
// memory port. The instruction-fetch lane (m0) and the data lane (m1) compete
// for the slave port (s_*). The winner keeps the port for its whole burst.
// Command, write beats and read beats pass through with no registered latency.
//
// Ports:
//   clk, rst            clock, asynchronous active-high reset
//   mN_address/burstcount/read/write/writedata/byteenable   requester N command
//   mN_waitrequest      stall to requester N
//   mN_readdata/response   slave return data, broadcast to both requesters
//   mN_readdatavalid    read beat valid, owner of the burst only
//   s_*                 shared slave port
//
// Build option: define ARMLEOCPU_ARB_FIXED_PRIORITY_EN to make m0 always win a
// simultaneous request. By default the arbiter is round-robin.

module armleocpu_mem_arbiter #(
  parameter int unsigned ADDR_W  = 34,
  parameter int unsigned BURST_W = 5
) (
  input  logic               clk,
  input  logic               rst,

  input  logic [ADDR_W-1:0]  m0_address,
  input  logic [BURST_W-1:0] m0_burstcount,
  input  logic               m0_read,
  input  logic               m0_write,
  input  logic [31:0]        m0_writedata,
  input  logic [3:0]         m0_byteenable,
  output logic               m0_waitrequest,
  output logic [31:0]        m0_readdata,
  output logic [1:0]         m0_response,
  output logic               m0_readdatavalid,

  input  logic [ADDR_W-1:0]  m1_address,
  input  logic [BURST_W-1:0] m1_burstcount,
  input  logic               m1_read,
  input  logic               m1_write,
  input  logic [31:0]        m1_writedata,
  input  logic [3:0]         m1_byteenable,
  output logic               m1_waitrequest,
  output logic [31:0]        m1_readdata,
  output logic [1:0]         m1_response,
  output logic               m1_readdatavalid,

  output logic [ADDR_W-1:0]  s_address,
  output logic [BURST_W-1:0] s_burstcount,
  output logic               s_read,
  output logic               s_write,
  output logic [31:0]        s_writedata,
  output logic [3:0]         s_byteenable,
  input  logic               s_waitrequest,
  input  logic [31:0]        s_readdata,
  input  logic               s_readdatavalid,
  input  logic [1:0]         s_response
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    RBURST = 2'd1,
    WBURST = 2'd2
  } state_t;

  state_t             state;
  state_t             state_nxt;
  logic [BURST_W-1:0] beats_left;
  logic [BURST_W-1:0] burst_q;
  logic               owner;
  logic               last_grant;

  logic               req0;
  logic               req1;
  logic               any_req;
  logic               grant;
  logic               sel;
  logic [ADDR_W-1:0]  sel_address;
  logic [BURST_W-1:0] sel_burstcount;
  logic               sel_read;
  logic               sel_write;
  logic [31:0]        sel_writedata;
  logic [3:0]         sel_byteenable;
  logic [BURST_W-1:0] burst_len;
  logic               cmd_accept;
  logic               wbeat_accept;
  logic               rbeat;
  logic               last_beat;

  assign req0    = m0_read | m0_write;
  assign req1    = m1_read | m1_write;
  assign any_req = req0 | req1;

  // Same-cycle grant; only meaningful while IDLE
  always_comb begin
`ifdef ARMLEOCPU_ARB_FIXED_PRIORITY_EN
    grant = !req0 && req1;
`else
    grant = (req0 && req1) ? !last_grant : req1;
`endif
  end

  // While IDLE the granted lane drives the port; during a burst the owner does
  assign sel = (state == IDLE) ? grant : owner;

  always_comb begin
    sel_address    = sel ? m1_address    : m0_address;
    sel_burstcount = sel ? m1_burstcount : m0_burstcount;
    sel_read       = sel ? m1_read       : m0_read;
    sel_write      = sel ? m1_write      : m0_write;
    sel_writedata  = sel ? m1_writedata  : m0_writedata;
    sel_byteenable = sel ? m1_byteenable : m0_byteenable;
  end

  // A burstcount of zero is a single beat
  assign burst_len    = (sel_burstcount == '0) ? BURST_W'(1) : sel_burstcount;
  assign cmd_accept   = (state == IDLE) && (sel_read || sel_write) && !s_waitrequest;
  assign wbeat_accept = (state == WBURST) && sel_write && !s_waitrequest;
  assign rbeat        = (state == RBURST) && s_readdatavalid;
  assign last_beat    = (beats_left == BURST_W'(1));

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state logic
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: begin
        if (cmd_accept) begin
          if (sel_read) begin
            state_nxt = RBURST;
          end else if (burst_len != BURST_W'(1)) begin
            state_nxt = WBURST;
          end
        end
      end
      RBURST: begin
        if (rbeat && last_beat) begin
          state_nxt = IDLE;
        end
      end
      WBURST: begin
        if (wbeat_accept && last_beat) begin
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Burst bookkeeping: owner, remaining beats, latched length, fairness pointer
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      beats_left <= '0;
      burst_q    <= '0;
      owner      <= 1'b0;
      last_grant <= 1'b1;
    end else begin
      case (state)
        IDLE: begin
          if (cmd_accept) begin
            if (sel_read) begin
              owner      <= grant;
              beats_left <= burst_len;
              burst_q    <= sel_burstcount;
            end else if (burst_len == BURST_W'(1)) begin
              // single-beat write completes on acceptance
              last_grant <= grant;
            end else begin
              owner      <= grant;
              beats_left <= burst_len - BURST_W'(1);
              burst_q    <= sel_burstcount;
            end
          end
        end
        RBURST: begin
          if (rbeat) begin
            beats_left <= beats_left - BURST_W'(1);
            if (last_beat) begin
              last_grant <= owner;
            end
          end
        end
        WBURST: begin
          if (wbeat_accept) begin
            beats_left <= beats_left - BURST_W'(1);
            if (last_beat) begin
              last_grant <= owner;
            end
          end
        end
        default: ;
      endcase
    end
  end

  // Port steering; reset forces the quiet values regardless of inputs
  always_comb begin
    s_address        = '0;
    s_burstcount     = '0;
    s_read           = 1'b0;
    s_write          = 1'b0;
    s_writedata      = '0;
    s_byteenable     = '0;
    m0_waitrequest   = 1'b1;
    m1_waitrequest   = 1'b1;
    m0_readdatavalid = 1'b0;
    m1_readdatavalid = 1'b0;
    if (!rst) begin
      case (state)
        IDLE: begin
          if (any_req) begin
            s_address    = sel_address;
            s_burstcount = sel_burstcount;
            s_read       = sel_read;
            s_write      = sel_write;
            s_writedata  = sel_writedata;
            s_byteenable = sel_byteenable;
            if (grant) begin
              m1_waitrequest = s_waitrequest;
            end else begin
              m0_waitrequest = s_waitrequest;
            end
          end
        end
        RBURST: begin
          if (owner) begin
            m1_readdatavalid = s_readdatavalid;
          end else begin
            m0_readdatavalid = s_readdatavalid;
          end
        end
        WBURST: begin
          s_address    = sel_address;
          s_burstcount = burst_q;
          s_write      = sel_write;
          s_writedata  = sel_writedata;
          s_byteenable = sel_byteenable;
          if (owner) begin
            m1_waitrequest = s_waitrequest;
          end else begin
            m0_waitrequest = s_waitrequest;
          end
        end
        default: ;
      endcase
    end
  end

  // Return data and response go to both lanes; readdatavalid picks the owner
  assign m0_readdata = s_readdata;
  assign m1_readdata = s_readdata;
  assign m0_response = s_response;
  assign m1_response = s_response;

endmodule

// File: tb/tb_armleocpu_mem_arbiter.sv
// Directed bench for armleocpu_mem_arbiter. Inputs change just after each
// falling edge and outputs are sampled 1ns later, away from the rising edge.
module tb_armleocpu_mem_arbiter;

  localparam int unsigned ADDR_W  = 34;
  localparam int unsigned BURST_W = 5;

  logic               clk = 1'b0;
  logic               rst;
  logic [ADDR_W-1:0]  m0_address, m1_address;
  logic [BURST_W-1:0] m0_burstcount, m1_burstcount;
  logic               m0_read, m0_write, m1_read, m1_write;
  logic [31:0]        m0_writedata, m1_writedata;
  logic [3:0]         m0_byteenable, m1_byteenable;
  logic               m0_waitrequest, m1_waitrequest;
  logic [31:0]        m0_readdata, m1_readdata;
  logic [1:0]         m0_response, m1_response;
  logic               m0_readdatavalid, m1_readdatavalid;
  logic [ADDR_W-1:0]  s_address;
  logic [BURST_W-1:0] s_burstcount;
  logic               s_read, s_write;
  logic [31:0]        s_writedata;
  logic [3:0]         s_byteenable;
  logic               s_waitrequest;
  logic [31:0]        s_readdata;
  logic               s_readdatavalid;
  logic [1:0]         s_response;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  armleocpu_mem_arbiter #(.ADDR_W(ADDR_W), .BURST_W(BURST_W)) dut (
    .clk(clk), .rst(rst),
    .m0_address(m0_address), .m0_burstcount(m0_burstcount), .m0_read(m0_read),
    .m0_write(m0_write), .m0_writedata(m0_writedata), .m0_byteenable(m0_byteenable),
    .m0_waitrequest(m0_waitrequest), .m0_readdata(m0_readdata),
    .m0_response(m0_response), .m0_readdatavalid(m0_readdatavalid),
    .m1_address(m1_address), .m1_burstcount(m1_burstcount), .m1_read(m1_read),
    .m1_write(m1_write), .m1_writedata(m1_writedata), .m1_byteenable(m1_byteenable),
    .m1_waitrequest(m1_waitrequest), .m1_readdata(m1_readdata),
    .m1_response(m1_response), .m1_readdatavalid(m1_readdatavalid),
    .s_address(s_address), .s_burstcount(s_burstcount), .s_read(s_read),
    .s_write(s_write), .s_writedata(s_writedata), .s_byteenable(s_byteenable),
    .s_waitrequest(s_waitrequest), .s_readdata(s_readdata),
    .s_readdatavalid(s_readdatavalid), .s_response(s_response)
  );

  task automatic clear_inputs();
    m0_address = '0; m0_burstcount = '0; m0_read = 0; m0_write = 0;
    m0_writedata = '0; m0_byteenable = '0;
    m1_address = '0; m1_burstcount = '0; m1_read = 0; m1_write = 0;
    m1_writedata = '0; m1_byteenable = '0;
    s_waitrequest = 0; s_readdata = '0; s_readdatavalid = 0; s_response = '0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    clear_inputs();
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_reset();
    @(negedge clk);
    rst = 1'b1;
    m0_read = 1; m1_write = 1; s_readdatavalid = 1;
    #1;
    total++; if (s_read !== 1'b0) begin bad++; $display("FAIL rst_s_read: got %b want 0", s_read); end
    total++; if (s_write !== 1'b0) begin bad++; $display("FAIL rst_s_write: got %b want 0", s_write); end
    total++; if ({m0_waitrequest, m1_waitrequest} !== 2'b11) begin bad++; $display("FAIL rst_wait: got %b want 11", {m0_waitrequest, m1_waitrequest}); end
    total++; if ({m0_readdatavalid, m1_readdatavalid} !== 2'b00) begin bad++; $display("FAIL rst_rdv: got %b want 00", {m0_readdatavalid, m1_readdatavalid}); end
    @(negedge clk);
    rst = 1'b0;
    clear_inputs();
  endtask

  task automatic test_read_burst4();
    do_reset();
    @(negedge clk);
    m0_read = 1; m0_address = 34'h2_0000_0123; m0_burstcount = 5'd4; m0_byteenable = 4'hF;
    #1;
    total++; if (s_read !== 1'b1 || s_address !== 34'h2_0000_0123) begin bad++; $display("FAIL rd4_cmd: got read=%b addr=%h want 1 200000123", s_read, s_address); end
    total++; if (s_burstcount !== 5'd4) begin bad++; $display("FAIL rd4_bc: got %0d want 4", s_burstcount); end
    total++; if ({m0_waitrequest, m1_waitrequest} !== 2'b01) begin bad++; $display("FAIL rd4_grant: got %b want 01", {m0_waitrequest, m1_waitrequest}); end
    @(negedge clk);
    m0_read = 0;
    #1;
    total++; if (s_read !== 1'b0 || m0_waitrequest !== 1'b1) begin bad++; $display("FAIL rd4_busy: got read=%b wait=%b want 0 1", s_read, m0_waitrequest); end
    for (int i = 0; i < 4; i++) begin
      if (i == 2) begin
        @(negedge clk);
        s_readdatavalid = 0;
        #1;
        total++; if (m0_readdatavalid !== 1'b0) begin bad++; $display("FAIL rd4_gap: got %b want 0", m0_readdatavalid); end
      end
      @(negedge clk);
      s_readdatavalid = 1; s_readdata = 32'hA0 + 32'(i);
      #1;
      total++; if (m0_readdatavalid !== 1'b1 || m0_readdata !== 32'hA0 + 32'(i)) begin bad++; $display("FAIL rd4_beat%0d: got v=%b d=%h want 1 %h", i, m0_readdatavalid, m0_readdata, 32'hA0 + 32'(i)); end
      total++; if (m1_readdatavalid !== 1'b0) begin bad++; $display("FAIL rd4_m1rdv%0d: got %b want 0", i, m1_readdatavalid); end
    end
    @(negedge clk);
    s_readdata = 32'hEE;
    #1;
    total++; if (m0_readdatavalid !== 1'b0) begin bad++; $display("FAIL rd4_stray: got %b want 0", m0_readdatavalid); end
    @(negedge clk);
    clear_inputs();
  endtask

  task automatic test_round_robin();
    logic exp_g [3];
`ifdef ARMLEOCPU_ARB_FIXED_PRIORITY_EN
    exp_g = '{1'b0, 1'b0, 1'b0};
`else
    exp_g = '{1'b0, 1'b1, 1'b0};
`endif
    do_reset();
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      s_readdatavalid = 0;
      m0_read = 1; m0_address = 34'h100; m0_burstcount = 5'd1;
      m1_read = 1; m1_address = 34'h200; m1_burstcount = 5'd1;
      #1;
      total++; if ({m0_waitrequest, m1_waitrequest} !== (exp_g[k] ? 2'b10 : 2'b01)) begin bad++; $display("FAIL rr_grant%0d: got %b want %b", k, {m0_waitrequest, m1_waitrequest}, exp_g[k] ? 2'b10 : 2'b01); end
      total++; if (s_address !== (exp_g[k] ? 34'h200 : 34'h100)) begin bad++; $display("FAIL rr_addr%0d: got %h want %h", k, s_address, exp_g[k] ? 34'h200 : 34'h100); end
      @(negedge clk);
      s_readdatavalid = 1; s_readdata = 32'(k);
      #1;
      total++; if ({m0_readdatavalid, m1_readdatavalid} !== (exp_g[k] ? 2'b01 : 2'b10)) begin bad++; $display("FAIL rr_rdv%0d: got %b want %b", k, {m0_readdatavalid, m1_readdatavalid}, exp_g[k] ? 2'b01 : 2'b10); end
    end
    @(negedge clk);
    clear_inputs();
  endtask

  task automatic test_write_burst3();
    do_reset();
    @(negedge clk);
    m1_write = 1; m1_address = 34'h3_0000_0040; m1_burstcount = 5'd3;
    m1_writedata = 32'hD0; m1_byteenable = 4'hF;
    #1;
    total++; if (s_write !== 1'b1 || s_writedata !== 32'hD0 || m1_waitrequest !== 1'b0) begin bad++; $display("FAIL wr_b1: got w=%b d=%h wait=%b want 1 d0 0", s_write, s_writedata, m1_waitrequest); end
    @(negedge clk);
    m1_writedata = 32'hD1; s_waitrequest = 1;
    m0_read = 1; m0_address = 34'h80; m0_burstcount = 5'd1;
    #1;
    total++; if (s_write !== 1'b1 || s_read !== 1'b0 || s_writedata !== 32'hD1 || s_burstcount !== 5'd3) begin bad++; $display("FAIL wr_b2: got w=%b r=%b d=%h bc=%0d want 1 0 d1 3", s_write, s_read, s_writedata, s_burstcount); end
    total++; if ({m0_waitrequest, m1_waitrequest} !== 2'b11) begin bad++; $display("FAIL wr_stall1: got %b want 11", {m0_waitrequest, m1_waitrequest}); end
    @(negedge clk);
    #1;
    total++; if ({m0_waitrequest, m1_waitrequest} !== 2'b11 || s_writedata !== 32'hD1) begin bad++; $display("FAIL wr_stall2: got %b d=%h want 11 d1", {m0_waitrequest, m1_waitrequest}, s_writedata); end
    @(negedge clk);
    s_waitrequest = 0;
    #1;
    total++; if ({m0_waitrequest, m1_waitrequest} !== 2'b10 || s_writedata !== 32'hD1) begin bad++; $display("FAIL wr_b2acc: got %b d=%h want 10 d1", {m0_waitrequest, m1_waitrequest}, s_writedata); end
    @(negedge clk);
    m1_writedata = 32'hD2;
    #1;
    total++; if ({m0_waitrequest, m1_waitrequest} !== 2'b10 || s_writedata !== 32'hD2 || s_write !== 1'b1) begin bad++; $display("FAIL wr_b3: got %b d=%h w=%b want 10 d2 1", {m0_waitrequest, m1_waitrequest}, s_writedata, s_write); end
    @(negedge clk);
    m1_write = 0;
    #1;
    total++; if (m0_waitrequest !== 1'b0 || s_read !== 1'b1 || s_write !== 1'b0 || s_address !== 34'h80) begin bad++; $display("FAIL wr_m0grant: got wait=%b r=%b w=%b a=%h want 0 1 0 80", m0_waitrequest, s_read, s_write, s_address); end
    @(negedge clk);
    m0_read = 0; s_readdatavalid = 1; s_readdata = 32'h55;
    #1;
    total++; if (m0_readdatavalid !== 1'b1 || m1_readdatavalid !== 1'b0) begin bad++; $display("FAIL wr_m0beat: got %b%b want 10", m0_readdatavalid, m1_readdatavalid); end
    @(negedge clk);
    clear_inputs();
  endtask

  task automatic test_error_response();
    do_reset();
    @(negedge clk);
    m0_read = 1; m0_address = 34'h44; m0_burstcount = 5'd2;
    #1;
    total++; if (m0_waitrequest !== 1'b0) begin bad++; $display("FAIL err_grant: got %b want 0", m0_waitrequest); end
    @(negedge clk);
    m0_read = 0; s_readdatavalid = 1; s_response = 2'b11; s_readdata = 32'h1;
    #1;
    total++; if (m0_readdatavalid !== 1'b1 || m0_response !== 2'b11 || m1_response !== 2'b11) begin bad++; $display("FAIL err_beat1: got v=%b r0=%b r1=%b want 1 11 11", m0_readdatavalid, m0_response, m1_response); end
    @(negedge clk);
    s_response = 2'b00; s_readdata = 32'h2;
    #1;
    total++; if (m0_readdatavalid !== 1'b1 || m0_response !== 2'b00 || m0_readdata !== 32'h2) begin bad++; $display("FAIL err_beat2: got v=%b r=%b d=%h want 1 00 2", m0_readdatavalid, m0_response, m0_readdata); end
    @(negedge clk);
    #1;
    total++; if (m0_readdatavalid !== 1'b0) begin bad++; $display("FAIL err_done: got %b want 0", m0_readdatavalid); end
    @(negedge clk);
    clear_inputs();
  endtask

  task automatic test_reset_midburst();
    do_reset();
    @(negedge clk);
    m0_read = 1; m0_address = 34'h600; m0_burstcount = 5'd4;
    @(negedge clk);
    m0_read = 0; s_readdatavalid = 1; s_readdata = 32'hB0;
    #1;
    total++; if (m0_readdatavalid !== 1'b1) begin bad++; $display("FAIL mrst_beat1: got %b want 1", m0_readdatavalid); end
    @(negedge clk);
    rst = 1'b1; s_readdata = 32'hB1;
    #1;
    total++; if (m0_readdatavalid !== 1'b0 || {m0_waitrequest, m1_waitrequest} !== 2'b11 || s_read !== 1'b0) begin bad++; $display("FAIL mrst_assert: got v=%b w=%b r=%b want 0 11 0", m0_readdatavalid, {m0_waitrequest, m1_waitrequest}, s_read); end
    for (int i = 2; i < 4; i++) begin
      @(negedge clk);
      rst = 1'b0; s_readdata = 32'hB0 + 32'(i);
      #1;
      total++; if ({m0_readdatavalid, m1_readdatavalid} !== 2'b00) begin bad++; $display("FAIL mrst_late%0d: got %b want 00", i, {m0_readdatavalid, m1_readdatavalid}); end
    end
    @(negedge clk);
    s_readdatavalid = 0;
    m1_read = 1; m1_address = 34'h700; m1_burstcount = 5'd1;
    #1;
    total++; if (m1_waitrequest !== 1'b0 || s_read !== 1'b1 || s_address !== 34'h700) begin bad++; $display("FAIL mrst_m1grant: got wait=%b r=%b a=%h want 0 1 700", m1_waitrequest, s_read, s_address); end
    @(negedge clk);
    m1_read = 0; s_readdatavalid = 1; s_readdata = 32'hC0;
    #1;
    total++; if (m1_readdatavalid !== 1'b1 || m1_readdata !== 32'hC0) begin bad++; $display("FAIL mrst_m1beat: got v=%b d=%h want 1 c0", m1_readdatavalid, m1_readdata); end
    @(negedge clk);
    clear_inputs();
  endtask

  task automatic test_burst_zero();
    do_reset();
    @(negedge clk);
    m0_read = 1; m0_address = 34'h900; m0_burstcount = 5'd0;
    #1;
    total++; if (m0_waitrequest !== 1'b0 || s_read !== 1'b1) begin bad++; $display("FAIL bz_grant: got wait=%b r=%b want 0 1", m0_waitrequest, s_read); end
    @(negedge clk);
    m0_read = 0; s_readdatavalid = 1; s_readdata = 32'h99;
    #1;
    total++; if (m0_readdatavalid !== 1'b1) begin bad++; $display("FAIL bz_beat: got %b want 1", m0_readdatavalid); end
    @(negedge clk);
    #1;
    total++; if (m0_readdatavalid !== 1'b0) begin bad++; $display("FAIL bz_idle: got %b want 0", m0_readdatavalid); end
    @(negedge clk);
    clear_inputs();
  endtask

  initial begin
    #100000;
    $display("FAIL timeout: got no finish want finish");
    $fatal(1, "timeout");
  end

  initial begin
    rst = 1'b1;
    clear_inputs();
    test_reset();
    test_read_burst4();
    test_round_robin();
    test_write_burst3();
    test_error_response();
    test_reset_midburst();
    test_burst_zero();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
